// File: rtl/priority_arbiter.sv
// Registered N-way request arbiter with a valid/ready handshake on both sides.
// The encoder is combinational from req and rr_ptr; only the result stage and rr_ptr hold state.
module priority_arbiter #(
  parameter int unsigned N           = 8,
  parameter bit          ROUND_ROBIN = 1'b0,
  localparam int unsigned W          = $clog2(N)
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic [N-1:0] req_i,
  input  logic         req_valid_i,
  output logic         req_ready_o,
  output logic         grant_valid_o,
  input  logic         grant_ready_i,
  output logic [W-1:0] grant_idx_o,
  output logic [N-1:0] grant_onehot_o,
  output logic         grant_none_o
);

  logic         grant_valid_q, grant_valid_d;
  logic [W-1:0] grant_idx_q, grant_idx_d;
  logic [N-1:0] grant_onehot_q, grant_onehot_d;
  logic         grant_none_q, grant_none_d;
  logic [W-1:0] rr_ptr_q, rr_ptr_d;

  logic         accept;
  logic [N-1:0] rr_mask;
  logic [N-1:0] req_masked;
  logic [N-1:0] search;
  logic         win_found;
  logic [W-1:0] win_idx;
  logic [N-1:0] win_onehot;

  assign req_ready_o = !grant_valid_q || grant_ready_i;
  assign accept      = req_valid_i && req_ready_o;

  // Round-robin search: bits at or above rr_ptr first, otherwise fall back to the full vector,
  // which yields the wrap-around order rr_ptr..N-1 then 0..rr_ptr-1. In fixed mode the mask is
  // empty, so the full vector is always searched from bit 0.
  always_comb begin
    rr_mask = '0;
    for (int i = 0; i < N; i++) begin
      rr_mask[i] = ROUND_ROBIN && (i >= int'(rr_ptr_q));
    end
    req_masked = req_i & rr_mask;
    search     = (|req_masked) ? req_masked : req_i;
    win_found  = |req_i;
  end

  always_comb begin
    win_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (search[i]) begin
        win_idx = W'(i);
      end
    end
    win_onehot = '0;
    for (int i = 0; i < N; i++) begin
      win_onehot[i] = win_found && (win_idx == W'(i));
    end
  end

  always_comb begin
    grant_valid_d  = grant_valid_q;
    grant_idx_d    = grant_idx_q;
    grant_onehot_d = grant_onehot_q;
    grant_none_d   = grant_none_q;
    rr_ptr_d       = rr_ptr_q;
    if (accept) begin
      grant_valid_d  = 1'b1;
      grant_idx_d    = win_idx;
      grant_onehot_d = win_onehot;
      grant_none_d   = !win_found;
      // Wrap at N-1 explicitly so a non-power-of-two N never lands on an unused index.
      if (ROUND_ROBIN && win_found) begin
        rr_ptr_d = (win_idx == W'(N - 1)) ? '0 : win_idx + W'(1);
      end
    end else if (grant_ready_i) begin
      grant_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      grant_valid_q  <= 1'b0;
      grant_idx_q    <= '0;
      grant_onehot_q <= '0;
      grant_none_q   <= 1'b0;
      rr_ptr_q       <= '0;
    end else begin
      grant_valid_q  <= grant_valid_d;
      grant_idx_q    <= grant_idx_d;
      grant_onehot_q <= grant_onehot_d;
      grant_none_q   <= grant_none_d;
      rr_ptr_q       <= rr_ptr_d;
    end
  end

  assign grant_valid_o  = grant_valid_q;
  assign grant_idx_o    = grant_idx_q;
  assign grant_onehot_o = grant_onehot_q;
  assign grant_none_o   = grant_none_q;

endmodule

// File: tb/tb_priority_arbiter.sv
// Directed bench for priority_arbiter: fixed N=8, round-robin N=8 and round-robin N=5 instances
// share one stimulus bus; each phase resets all three and checks one of them.
module tb_priority_arbiter;

  typedef struct {
    logic [7:0] req;
    logic [2:0] idx;
    logic [7:0] onehot;
    logic       none;
  } vec_t;

  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic       req_valid;
  logic       grant_ready;

  logic       a_ready, a_gv, a_none;
  logic [2:0] a_idx;
  logic [7:0] a_oh;
  logic       b_ready, b_gv, b_none;
  logic [2:0] b_idx;
  logic [7:0] b_oh;
  logic       c_ready, c_gv, c_none;
  logic [2:0] c_idx;
  logic [4:0] c_oh;

  logic [1:0] sel;
  logic       obs_ready, obs_gv, obs_none;
  logic [2:0] obs_idx;
  logic [7:0] obs_oh;

  int errors;
  int checks;

  vec_t fix_tbl[8];
  vec_t rr8_tbl[17];
  vec_t rr5_tbl[8];

  priority_arbiter #(.N(8), .ROUND_ROBIN(1'b0)) u_fix (
    .clk_i(clk), .reset_i(reset), .req_i(req), .req_valid_i(req_valid),
    .req_ready_o(a_ready), .grant_valid_o(a_gv), .grant_ready_i(grant_ready),
    .grant_idx_o(a_idx), .grant_onehot_o(a_oh), .grant_none_o(a_none)
  );

  priority_arbiter #(.N(8), .ROUND_ROBIN(1'b1)) u_rr8 (
    .clk_i(clk), .reset_i(reset), .req_i(req), .req_valid_i(req_valid),
    .req_ready_o(b_ready), .grant_valid_o(b_gv), .grant_ready_i(grant_ready),
    .grant_idx_o(b_idx), .grant_onehot_o(b_oh), .grant_none_o(b_none)
  );

  priority_arbiter #(.N(5), .ROUND_ROBIN(1'b1)) u_rr5 (
    .clk_i(clk), .reset_i(reset), .req_i(req[4:0]), .req_valid_i(req_valid),
    .req_ready_o(c_ready), .grant_valid_o(c_gv), .grant_ready_i(grant_ready),
    .grant_idx_o(c_idx), .grant_onehot_o(c_oh), .grant_none_o(c_none)
  );

  always_comb begin
    case (sel)
      2'd1:    begin obs_ready = b_ready; obs_gv = b_gv; obs_idx = b_idx;
                     obs_oh = b_oh; obs_none = b_none; end
      2'd2:    begin obs_ready = c_ready; obs_gv = c_gv; obs_idx = c_idx;
                     obs_oh = {3'b000, c_oh}; obs_none = c_none; end
      default: begin obs_ready = a_ready; obs_gv = a_gv; obs_idx = a_idx;
                     obs_oh = a_oh; obs_none = a_none; end
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    req         = '0;
    req_valid   = 1'b0;
    grant_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    req         = v.req;
    req_valid   = 1'b1;
    grant_ready = 1'b1;
    #1;
    check({tag, ".ready"}, 32'(obs_ready), 32'd1);
    tick();
    check({tag, ".valid"}, 32'(obs_gv), 32'd1);
    check({tag, ".idx"}, 32'(obs_idx), 32'(v.idx));
    check({tag, ".onehot"}, 32'(obs_oh), 32'(v.onehot));
    check({tag, ".none"}, 32'(obs_none), 32'(v.none));
  endtask

  initial begin
    errors = 0;
    checks = 0;
    sel    = 2'd0;

    fix_tbl[0] = '{8'b1010_0100, 3'd2, 8'h04, 1'b0};
    fix_tbl[1] = '{8'h80, 3'd7, 8'h80, 1'b0};
    fix_tbl[2] = '{8'h00, 3'd0, 8'h00, 1'b1};
    fix_tbl[3] = '{8'h06, 3'd1, 8'h02, 1'b0};
    fix_tbl[4] = '{8'h08, 3'd3, 8'h08, 1'b0};
    fix_tbl[5] = '{8'hFF, 3'd0, 8'h01, 1'b0};
    fix_tbl[6] = '{8'h40, 3'd6, 8'h40, 1'b0};
    fix_tbl[7] = '{8'hC0, 3'd6, 8'h40, 1'b0};

    for (int i = 0; i < 10; i++) begin
      rr8_tbl[i] = '{8'hFF, 3'(i % 8), 8'h01 << (i % 8), 1'b0};
    end
    rr8_tbl[10] = '{8'h00, 3'd0, 8'h00, 1'b1};  // pointer stays at 2
    rr8_tbl[11] = '{8'hFF, 3'd2, 8'h04, 1'b0};
    rr8_tbl[12] = '{8'h03, 3'd0, 8'h01, 1'b0};  // nothing at 3..7, wraps to 0
    rr8_tbl[13] = '{8'h03, 3'd1, 8'h02, 1'b0};
    rr8_tbl[14] = '{8'h03, 3'd0, 8'h01, 1'b0};
    rr8_tbl[15] = '{8'h80, 3'd7, 8'h80, 1'b0};
    rr8_tbl[16] = '{8'h81, 3'd0, 8'h01, 1'b0};  // pointer wrapped 7 -> 0

    rr5_tbl[0] = '{8'h11, 3'd0, 8'h01, 1'b0};
    rr5_tbl[1] = '{8'h11, 3'd4, 8'h10, 1'b0};
    rr5_tbl[2] = '{8'h11, 3'd0, 8'h01, 1'b0};
    rr5_tbl[3] = '{8'h11, 3'd4, 8'h10, 1'b0};
    rr5_tbl[4] = '{8'h0A, 3'd1, 8'h02, 1'b0};
    rr5_tbl[5] = '{8'h0A, 3'd3, 8'h08, 1'b0};
    rr5_tbl[6] = '{8'h06, 3'd1, 8'h02, 1'b0};
    rr5_tbl[7] = '{8'h00, 3'd0, 8'h00, 1'b1};

    // Reset state
    do_reset();
    check("rst.valid", 32'(a_gv), 32'd0);
    check("rst.idx", 32'(a_idx), 32'd0);
    check("rst.onehot", 32'(a_oh), 32'd0);
    check("rst.none", 32'(a_none), 32'd0);
    check("rst.ready", 32'(a_ready), 32'd1);

    // Reset while stalled discards the held result
    req = 8'h10; req_valid = 1'b1; grant_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    #1;
    check("stall.valid", 32'(a_gv), 32'd1);
    check("stall.idx", 32'(a_idx), 32'd4);
    check("stall.ready", 32'(a_ready), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("rststall.valid", 32'(a_gv), 32'd0);
    check("rststall.idx", 32'(a_idx), 32'd0);
    check("rststall.onehot", 32'(a_oh), 32'd0);
    check("rststall.none", 32'(a_none), 32'd0);
    check("rststall.ready", 32'(a_ready), 32'd1);

    // Fixed priority, back to back
    do_reset();
    sel = 2'd0;
    foreach (fix_tbl[i]) run_vec(fix_tbl[i], $sformatf("fix[%0d]", i));

    // Backpressure: three stalled cycles with a changing request, then accept while draining
    do_reset();
    req = 8'h20; req_valid = 1'b1; grant_ready = 1'b1;
    tick();
    check("bp.first_idx", 32'(a_idx), 32'd5);
    grant_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req = 8'h02 << k;
      #1;
      check($sformatf("bp.ready[%0d]", k), 32'(a_ready), 32'd0);
      tick();
      check($sformatf("bp.valid[%0d]", k), 32'(a_gv), 32'd1);
      check($sformatf("bp.idx[%0d]", k), 32'(a_idx), 32'd5);
      check($sformatf("bp.onehot[%0d]", k), 32'(a_oh), 32'h20);
    end
    grant_ready = 1'b1;
    #1;
    check("bp.release_ready", 32'(a_ready), 32'd1);
    tick();
    check("bp.new_valid", 32'(a_gv), 32'd1);
    check("bp.new_idx", 32'(a_idx), 32'd3);
    check("bp.new_onehot", 32'(a_oh), 32'h08);
    req_valid = 1'b0;
    tick();
    check("bp.drained", 32'(a_gv), 32'd0);

    // Round-robin N=8
    do_reset();
    sel = 2'd1;
    foreach (rr8_tbl[i]) run_vec(rr8_tbl[i], $sformatf("rr8[%0d]", i));

    // Round-robin N=5
    do_reset();
    sel = 2'd2;
    foreach (rr5_tbl[i]) run_vec(rr5_tbl[i], $sformatf("rr5[%0d]", i));

    req_valid = 1'b0;
    tick();
    check("rr5.drained", 32'(c_gv), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
